// File: rtl/led_pattern_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encoding and
// direction constants used by the sequencer, board top and register map.
package led_pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  // Bounce direction flag: 0 walks towards the top LED, 1 walks back down.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_seq_tick_div.sv
// Step-rate divider: counts 0..P-1 with P = TICK_CNT >> speed and raises
// o_tick combinationally on the last count while enabled. The >= compare
// lets a switch to a shorter period fire immediately instead of wrapping.
module led_pattern_seq_tick_div #(
  parameter int unsigned TICK_CNT = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam int unsigned CW = $clog2(TICK_CNT);

  logic [CW-1:0] r_cnt;
  logic [31:0]   w_last;
  logic          w_tick;

  // Last count of the current period and the enabled end-of-period strobe.
  always_comb begin
    w_last = (32'(TICK_CNT) >> i_speed) - 32'd1;
    w_tick = i_en & (32'(r_cnt) >= w_last);
  end

  // Period counter: cleared on mode change or period end, frozen while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr || w_tick) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = w_tick;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances a rotate / bounce / bar-fill pattern once
// per divider tick and drives the LED pins with registered, polarity-adjusted
// outputs. A mode change restarts the pattern and the divider from zero.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int unsigned N_LED      = 6,
  parameter int unsigned TICK_CNT   = 50000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led_o,
  output logic             step_o
);

  localparam int unsigned      PW      = $clog2(N_LED + 1);
  localparam logic [PW-1:0]    POS_TOP = PW'(N_LED - 1);
  localparam logic [PW-1:0]    POS_ALL = PW'(N_LED);
  localparam logic [N_LED-1:0] POL     = {N_LED{ACTIVE_LOW}};
  localparam logic [N_LED-1:0] LED_RST = N_LED'(1'b1) ^ POL;

  mode_e            r_mode_q;
  logic [PW-1:0]    r_pos;
  logic             r_dir;
  logic [N_LED-1:0] r_led;
  logic             r_step;

  mode_e            w_mode_in;
  logic             w_mode_chg;
  logic             w_tick;
  logic [PW-1:0]    w_pos_nxt;
  logic             w_dir_nxt;

  // Polarity-free LED image for a mode and position.
  function automatic logic [N_LED-1:0] decode(input mode_e m, input logic [PW-1:0] p);
    logic [N_LED-1:0] v;
    case (m)
      MODE_FILL: v = ~({N_LED{1'b1}} << p);
      default:   v = N_LED'(1'b1) << p;
    endcase
    return v;
  endfunction

  led_pattern_seq_tick_div #(
    .TICK_CNT (TICK_CNT)
  ) u_div (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (en),
    .i_clr   (w_mode_chg),
    .i_speed (speed),
    .o_tick  (w_tick)
  );

  // Detect a requested mode that differs from the one being shown.
  always_comb begin
    w_mode_in  = mode_e'(mode);
    w_mode_chg = (w_mode_in != r_mode_q);
  end

  // Next position and bounce direction for the current mode.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    case (r_mode_q)
      MODE_ROT_L: begin
        if (r_pos >= POS_TOP) w_pos_nxt = PW'(0);
        else                  w_pos_nxt = r_pos + PW'(1);
      end
      MODE_ROT_R: begin
        if (r_pos == PW'(0)) w_pos_nxt = POS_TOP;
        else                 w_pos_nxt = r_pos - PW'(1);
      end
      MODE_BOUNCE: begin
        if (N_LED == 1) begin
          w_pos_nxt = PW'(0);
          w_dir_nxt = DIR_UP;
        end else if (r_dir == DIR_UP) begin
          if (r_pos >= POS_TOP) begin
            w_pos_nxt = r_pos - PW'(1);
            w_dir_nxt = DIR_DOWN;
          end else begin
            w_pos_nxt = r_pos + PW'(1);
          end
        end else begin
          if (r_pos == PW'(0)) begin
            w_pos_nxt = r_pos + PW'(1);
            w_dir_nxt = DIR_UP;
          end else begin
            w_pos_nxt = r_pos - PW'(1);
          end
        end
      end
      MODE_FILL: begin
        if (r_pos >= POS_ALL) w_pos_nxt = PW'(0);
        else                  w_pos_nxt = r_pos + PW'(1);
      end
      default: begin
        w_pos_nxt = PW'(0);
        w_dir_nxt = DIR_UP;
      end
    endcase
  end

  // Pattern state and output registers; a mode change outranks a tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode_q <= MODE_ROT_L;
      r_pos    <= PW'(0);
      r_dir    <= DIR_UP;
      r_led    <= LED_RST;
      r_step   <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode_q <= w_mode_in;
      r_pos    <= PW'(0);
      r_dir    <= DIR_UP;
      r_led    <= decode(w_mode_in, PW'(0)) ^ POL;
      r_step   <= 1'b0;
    end else if (w_tick) begin
      r_pos    <= w_pos_nxt;
      r_dir    <= w_dir_nxt;
      r_led    <= decode(r_mode_q, w_pos_nxt) ^ POL;
      r_step   <= 1'b1;
    end else begin
      r_step   <= 1'b0;
    end
  end

  assign led_o  = r_led;
  assign step_o = r_step;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: two instances (6 LEDs active-low, 1 LED
// active-high, TICK_CNT=8) driven by shared inputs, compared every cycle
// against a step-index model of the pattern sequences.
module tb_led_pattern_seq;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [5:0] led0;
  logic       step0;
  logic [0:0] led1;
  logic       step1;

  int tests = 0;
  int fails = 0;

  // Model state per instance: divider count, step index k within the
  // mode's period, displayed mode, and the step strobe.
  int cnt[2];
  int k[2];
  int mq[2];
  bit st[2];
  int nl[2]  = '{6, 1};
  bit al[2]  = '{1'b1, 1'b0};

  led_pattern_seq #(.N_LED(6), .TICK_CNT(8), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .speed(speed),
    .led_o(led0), .step_o(step0)
  );

  led_pattern_seq #(.N_LED(1), .TICK_CNT(8), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .speed(speed),
    .led_o(led1), .step_o(step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int period_of(int m, int n);
    case (m)
      0, 1:    return n;
      2:       return (n == 1) ? 1 : 2 * (n - 1);
      default: return n + 1;
    endcase
  endfunction

  function automatic int pos_of(int m, int kk, int n);
    case (m)
      0:       return kk;
      1:       return (n - kk) % n;
      2:       return (kk < n) ? kk : 2 * (n - 1) - kk;
      default: return kk;
    endcase
  endfunction

  function automatic logic [31:0] led_of(int m, int kk, int n, bit a);
    longint v;
    int p;
    p = pos_of(m, kk, n);
    if (m == 3) v = (64'sd1 <<< p) - 64'sd1;
    else        v = 64'sd1 <<< p;
    if (a) v = ~v;
    v = v & ((64'sd1 <<< n) - 64'sd1);
    return 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; k[i] = 0; mq[i] = 0; st[i] = 1'b0;
    end
  endtask

  // One rising edge of the model with the currently driven inputs.
  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      if (int'(mode) != mq[i]) begin
        mq[i] = int'(mode); k[i] = 0; cnt[i] = 0; st[i] = 1'b0;
      end else if (en && cnt[i] >= (8 >> speed) - 1) begin
        cnt[i] = 0;
        k[i]   = (k[i] + 1) % period_of(mq[i], nl[i]);
        st[i]  = 1'b1;
      end else begin
        st[i] = 1'b0;
        if (en) cnt[i] = cnt[i] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("led0",  32'(led0),  led_of(mq[0], k[0], nl[0], al[0]));
    check("step0", 32'(step0), 32'(st[0]));
    check("led1",  32'(led1),  led_of(mq[1], k[1], nl[1], al[1]));
    check("step1", 32'(step1), 32'(st[1]));
  endtask

  task automatic cycle();
    model_clock();
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges; outputs must reset at once.
  task automatic mid_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; mode = 2'd0; speed = 2'd0;
    model_reset();
    @(negedge clk);
    check("rst_led0", 32'(led0), 32'h3E);
    check_all();
    rstn = 1'b1;

    repeat (60)  cycle();
    mode = 2'd1; repeat (40)  cycle();
    mode = 2'd2; repeat (100) cycle();
    mode = 2'd3; repeat (70)  cycle();
    speed = 2'd3; repeat (10) cycle();
    speed = 2'd2; repeat (10) cycle();
    en = 1'b0;   repeat (20) cycle();
    en = 1'b1;   repeat (20) cycle();

    mode = 2'd0; speed = 2'd0; en = 1'b1;
    repeat (5) cycle();
    mid_reset();
    repeat (20) cycle();

    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 19) == 0) mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) en    = ~en;
      cycle();
      if (r % 500 == 250) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
